// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: accepts one word per valid/ready handshake and shifts out
// start, LSB-first data, optional parity and stop bits with its own baud timing.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast  = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast  = BitW'(STOP_BITS - 1);
  localparam logic             ParityOdd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign tx_ready = (state_q == StIdle);
  assign tx_out   = tx_out_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q == StIdle) begin
      baud_d = '0;
      bit_d  = '0;
      if (tx_valid) begin
        state_d  = StStart;
        shift_d  = tx_data;
        parity_d = (^tx_data) ^ ParityOdd;
      end
    end else if (baud_q != BaudLast) begin
      baud_d = baud_q + BaudW'(1);
    end else begin
      // Last clock of the current bit: advance to the next bit.
      baud_d = '0;
      case (state_q)
        StStart: begin
          state_d = StData;
          bit_d   = '0;
        end
        StData: begin
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
          end
        end
        StParity: begin
          state_d = StStop;
          bit_d   = '0;
        end
        StStop: begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line level and status are derived from next state so they register in step with it.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = shift_d[0];
      StParity: tx_out_d = parity_d;
      default:  tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StStop) && (baud_d == BaudLast) && (bit_d == StopLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations checked cycle by cycle against a
// frame model built from the UART framing rules.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] dat [4];
  wire  [3:0] rdy;
  wire  [3:0] txo;
  wire  [3:0] bsy;
  wire  [3:0] dn;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_data(dat[0]),
    .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_data(dat[1]),
    .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_data(dat[2]),
    .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(3), .DATA_BITS(5), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_data(dat[3][4:0]),
    .tx_out(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_cpb(input int u);
    return (u == 3) ? 3 : 4;
  endfunction

  function automatic int cfg_db(input int u);
    return (u == 3) ? 5 : 8;
  endfunction

  function automatic int cfg_pen(input int u);
    return (u == 1 || u == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_podd(input int u);
    return (u == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(input int u);
    return (u == 1 || u == 3) ? 2 : 1;
  endfunction

  // Bit-level frame for one word: start, data LSB first, optional parity, stop bits.
  task automatic build_frame(input int u, input logic [7:0] d);
    bit par;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    par = (cfg_podd(u) != 0);
    for (int i = 0; i < cfg_db(u); i++) begin
      exp_bits.push_back(d[i]);
      par ^= d[i];
    end
    if (cfg_pen(u) != 0) exp_bits.push_back(par);
    for (int s = 0; s < cfg_stop(u); s++) exp_bits.push_back(1'b1);
  endtask

  task automatic check_idle(input int u, input string tag);
    check_eq($sformatf("%s u%0d line", tag, u), txo[u], 1);
    check_eq($sformatf("%s u%0d ready", tag, u), rdy[u], 1);
    check_eq($sformatf("%s u%0d busy", tag, u), bsy[u], 0);
    check_eq($sformatf("%s u%0d done", tag, u), dn[u], 0);
  endtask

  // Called at a negedge with the instance idle; returns at the negedge of the idle gap.
  task automatic run_frame(input int u, input logic [7:0] d, input bit noisy, input bit chain,
                           input logic [7:0] nd);
    int cpb;
    int len;
    cpb = cfg_cpb(u);
    build_frame(u, d);
    len = exp_bits.size() * cpb;
    vld[u] = 1'b1;
    dat[u] = d;
    check_eq($sformatf("u%0d accept ready", u), rdy[u], 1);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d d%0h line c%0d", u, d, k), txo[u], exp_bits[(k - 1) / cpb]);
      check_eq($sformatf("u%0d busy c%0d", u, k), bsy[u], 1);
      check_eq($sformatf("u%0d ready c%0d", u, k), rdy[u], 0);
      check_eq($sformatf("u%0d done c%0d", u, k), dn[u], (k == len) ? 1 : 0);
      if (k == len) begin
        vld[u] = chain;
        dat[u] = nd;
      end else if (noisy) begin
        vld[u] = 1'($urandom_range(1, 0));
        dat[u] = 8'($urandom);
      end else begin
        vld[u] = 1'b0;
      end
    end
    @(negedge clk);
    check_idle(u, "gap");
  endtask

  initial begin
    int u;
    bit ch;
    bit nz;
    logic [7:0] d;
    logic [7:0] nd;

    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_idle(i, "reset");
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_idle(i, "idle");
    end

    run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00);
    run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00);

    // Held valid: second start bit lands two cycles after the first done pulse.
    run_frame(0, 8'h55, 1'b0, 1'b1, 8'hAA);
    run_frame(0, 8'hAA, 1'b0, 1'b0, 8'h00);

    // Abort during data bit 3 of 0x00 (cycles 17..20 of the frame).
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("abort pre line", txo[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "abort");
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check_eq($sformatf("abort line c%0d", c), txo[0], 1);
      check_eq($sformatf("abort done c%0d", c), dn[0], 0);
    end
    run_frame(0, 8'h3C, 1'b0, 1'b0, 8'h00);

    run_frame(0, 8'h81, 1'b1, 1'b0, 8'h00);

    u = 0;
    d = 8'($urandom);
    for (int it = 0; it < 40; it++) begin
      ch = 1'($urandom_range(1, 0));
      nz = 1'($urandom_range(1, 0));
      nd = 8'($urandom);
      run_frame(u, d, nz, ch, nd);
      if (ch) begin
        d = nd;
      end else begin
        u = $urandom_range(3, 0);
        d = 8'($urandom);
      end
    end
    vld = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Bit-level UART transmit datapath that sits directly downstream of the UART controller's TX state machine. It accepts one byte per valid/ready handshake and generates its own baud timing. It serialises start bit, LSB-first data, an optional parity bit and the stop bit(s) onto tx_out. It supplies the bit counting and line driving the controller relies on and reports busy/done back to it.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 = append parity bit after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  reset, synchronous and active-high.
tx_valid  input  1  byte offered by upstream controller.
tx_ready  output  1  high when the block can accept a byte; equals (state == IDLE).
tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
tx_out  output  1  serial line; registered; idles high.
tx_busy  output  1  high from the cycle after acceptance until the frame ends.
tx_done  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Reset (rst = 1 at clk edge): state = IDLE, tx_out = 1, tx_busy = 0, tx_done = 0, baud and bit counters = 0, shift register = 0. Reset wins over any simultaneous handshake.
- Reset mid-frame: frame aborts; tx_out = 1 from the next cycle; no tx_done pulse; next frame after reset is normal.
- Handshake: accept at the clk edge where tx_valid && tx_ready. At that edge: latch tx_data into the shift register, compute parity, state -> START.
- tx_valid while not ready is ignored; no queuing. tx_data changes during a frame have no effect.
- States:
  - IDLE: tx_out = 1.
  - START: tx_out = 0.
  - DATA: tx_out = shift[0]; shift right each bit; exactly DATA_BITS bits.
  - PARITY: entered only if PARITY_EN = 1. tx_out = ^data XOR PARITY_ODD.
  - STOP: tx_out = 1 for STOP_BITS bits, then -> IDLE.
- Each non-IDLE state bit lasts exactly CLKS_PER_BIT cycles. Baud counter width is $clog2(CLKS_PER_BIT); counter runs 0..CLKS_PER_BIT-1 and wraps on bit advance. Bit counter width is $clog2(DATA_BITS+1).
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles, from the cycle after acceptance to the tx_done cycle inclusive.
- tx_done and tx_busy are registered.
- Back-to-back frames: tx_ready rises in the first IDLE cycle after tx_done. With tx_valid held high the next byte is accepted at that edge, giving exactly one idle-high clk between frames.
- No combinational path from tx_valid or tx_data to tx_out.

Test Plan:
1. Reset, CLKS_PER_BIT=4 -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0; held for 20 idle cycles.
2. Send 0xA5, no parity, 1 stop -> tx_out = 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles. tx_done pulses once, on cycle 40 after the accept edge. tx_ready=0 throughout the frame.
3. PARITY_EN=1, send 0x07 -> parity bit 1 with PARITY_ODD=0, 0 with PARITY_ODD=1. Frame = 44 cycles. With STOP_BITS=2 -> 8 high stop cycles; tx_done at cycle 48.
4. tx_valid held high with 0x55 then 0xAA -> second start bit begins exactly 2 cycles after the first tx_done cycle. Both bytes decode correctly on a bench sampler.
5. Assert rst for 1 cycle during data bit 3 of 0x00 -> tx_out=1 the next cycle, no tx_done. A following send of 0x3C is bit-exact.
6. Change tx_data every cycle and pulse tx_valid during a frame of 0x81 -> line carries 0x81 only; the extra tx_valid pulses are not accepted.
